encoder83_serializer: RTL and testbench
=======================================

Name: encoder83_serializer

Overview:
- Inverse of the team's 3-to-8 enabled decoder: accepts an 8-bit multi-hot vector and emits the 3-bit index of every set bit, one per handshake, lowest index first.
- Sits between status/request bit-vectors (interrupt lines, lane-valid masks) and index-consuming logic.
- Feeding each emitted code and out_valid into the decoder as in/en reproduces the captured vector one bit per beat.

Parameters:
- WIDTH, 8, input vector width; fixed at 8 for this block.
- CODE_W, 3, output index width; equals $clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- en  input  1  acceptance enable; gates capture only
- in_valid  input  1  request vector valid
- in  input  8  multi-hot request vector
- in_ready  output  1  block can capture a vector
- out_valid  output  1  out_code valid
- out_code  output  3  index of the current lowest pending bit
- out_last  output  1  current code is the final one for this vector
- out_ready  input  1  consumer accepts the code
- zero_drop  output  1  one-cycle pulse: an all-zero vector was captured and discarded

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pending <= 0, state <= IDLE, zero_drop <= 0.
  - All outputs read 0, including in_ready during reset.
  - Applies mid-drain: undelivered codes are lost, with no partial output afterwards.
- States: IDLE, DRAIN. Internal 8-bit pending register.
- IDLE:
  - in_ready = 1 (after reset released); out_valid = 0.
  - Capture fires when en & in_valid at a clk edge.
  - Nonzero in: pending <= in; go to DRAIN.
  - in == 0: pending unchanged; stay in IDLE; zero_drop = 1 for the next cycle only.
  - en = 0: no capture, whatever in_valid is.
- DRAIN:
  - in_ready = 0; out_valid = 1.
  - out_code = index of the lowest set bit of pending. This is a combinational function of the register, so it stays stable while stalled.
  - out_last = 1 when popcount(pending) == 1.
  - On out_valid & out_ready: clear that bit in pending.
  - If out_last was 1 on that handshake, go to IDLE.
- Latency:
  - Capture at edge N gives out_valid = 1 in cycle N+1.
  - A vector with k set bits needs k handshakes, at best k consecutive cycles.
  - After the last handshake, in_ready = 1 the following cycle. Capture and emit never overlap.
- Backpressure: while out_ready = 0, out_code, out_last and pending hold. There is no timeout.
- en falling during DRAIN has no effect; the drain completes.
- in and in_valid are ignored outside IDLE.
- Index rule: bit i maps to code i (bit 0 = 3'd0, bit 7 = 3'd7), matching the decoder's out1[i] mapping.

Optional Feature:
- Macro: ENCODER83_MSB_FIRST_EN.
- Defined: scan order reverses. out_code is the highest set bit of pending and bits drain 7 down to 0. out_last still means popcount == 1.
- Undefined: LSB-first, as specified above.
- Port list and timing are identical in both builds.

Decomposition:
- Shared package encoder_pkg: WIDTH and CODE_W localparams, and the state enum {IDLE, DRAIN}.
- One natural sub-module: prio_enc83, purely combinational.
  - Inputs: 8-bit vector.
  - Outputs: 3-bit code, any-set flag, single-bit flag.
  - Selects LSB-first or MSB-first under the macro.
- Top: FSM, pending register, handshake.

Test Plan:
- Reset, then in=8'b1010_0100 with in_valid=en=1 and out_ready held 1:
  - codes 2, 5, 7 on three consecutive cycles;
  - out_last only on code 7;
  - in_ready back to 1 the next cycle.
- in=8'h80 with out_ready=0 for 4 cycles, then 1:
  - out_code=7 and out_last=1, held stable for 4 cycles;
  - a single handshake, then IDLE.
- in=8'h00 captured:
  - zero_drop pulses 1 for exactly one cycle;
  - out_valid stays 0; in_ready stays 1.
- en=0 with in_valid=1 and in=8'hFF: no capture and no out_valid. Then en=1: codes 0..7, with out_last on 7.
- rst_n=0 asserted after two of eight 8'hFF codes are delivered:
  - next cycle out_valid=0 and pending=0;
  - after release, in_ready=1.
- With ENCODER83_MSB_FIRST_EN defined and in=8'b0001_0011: codes 4, 1, 0, with out_last on 0.

Source files
------------

// File: rtl/encoder_pkg.sv
// Shared definitions for the 8-to-3 encoder serializer: vector/code widths and FSM states.
package encoder_pkg;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CODE_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

endpackage

// File: rtl/prio_enc83.sv
// Combinational 8-to-3 priority encoder; LSB-first by default, MSB-first when
// ENCODER83_MSB_FIRST_EN is defined.
module prio_enc83
    import encoder_pkg::*;
(
    input  logic [WIDTH-1:0]  vec,
    output logic [CODE_W-1:0] code,
    output logic              any,
    output logic              single
);

    // Later loop iterations override earlier ones, so the iteration order
    // puts the winning end of the vector last.
    always_comb begin
        code = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
`ifdef ENCODER83_MSB_FIRST_EN
            if (vec[i]) code = CODE_W'(i);
`else
            if (vec[WIDTH-1-i]) code = CODE_W'(WIDTH-1-i);
`endif
        end
    end

    assign any    = |vec;
    assign single = any && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/encoder83_serializer.sv
// Captures a multi-hot vector and emits one index per handshake (order set by
// ENCODER83_MSB_FIRST_EN); all-zero captures are dropped with a zero_drop pulse.
module encoder83_serializer
    import encoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in,
    output logic              in_ready,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_code,
    output logic              out_last,
    input  logic              out_ready,
    output logic              zero_drop
);

    state_t            state, state_next;
    logic [WIDTH-1:0]  pending, pending_next;
    logic              zd_q, zd_next;
    logic [CODE_W-1:0] code;
    logic              pend_any, pend_single;

    prio_enc83 u_prio (
        .vec    (pending),
        .code   (code),
        .any    (pend_any),
        .single (pend_single)
    );

    // Outputs are forced low while reset is asserted, even before the edge lands.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = rst_n && (state == DRAIN) && pend_any;
    assign out_code  = out_valid ? code : '0;
    assign out_last  = out_valid && pend_single;
    assign zero_drop = rst_n && zd_q;

    always_comb begin
        state_next   = state;
        pending_next = pending;
        zd_next      = 1'b0;
        case (state)
            IDLE: begin
                if (en && in_valid) begin
                    if (in != '0) begin
                        pending_next = in;
                        state_next   = DRAIN;
                    end else begin
                        zd_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_valid && out_ready) begin
                    pending_next[code] = 1'b0;
                    if (pend_single) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
            zd_q    <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            zd_q    <= zd_next;
        end
    end

endmodule

// File: tb/tb_encoder83_serializer.sv
// Scoreboard bench for encoder83_serializer: directed scenarios plus random traffic.
module tb_encoder83_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_vec = 8'h00;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_last, zero_drop;
    logic [2:0] out_code;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [2:0] code;
        logic       last;
    } exp_t;

    exp_t q[$];
    logic zd_exp = 1'b0;

    encoder83_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in        (in_vec),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_last  (out_last),
        .out_ready (out_ready),
        .zero_drop (zero_drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference: list the set bits in scan order, the final one flagged last.
    function automatic void model_push(input logic [7:0] v);
        int n = $countones(v);
        int k = 0;
`ifdef ENCODER83_MSB_FIRST_EN
        for (int i = 7; i >= 0; i--) begin
`else
        for (int i = 0; i < 8; i++) begin
`endif
            if (v[i]) begin
                k++;
                q.push_back('{code: 3'(i), last: (k == n)});
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", {7'd0, in_ready}, 8'd0);
            check("rst_out_valid", {7'd0, out_valid}, 8'd0);
            check("rst_out_code", {5'd0, out_code}, 8'd0);
            check("rst_out_last", {7'd0, out_last}, 8'd0);
            check("rst_zero_drop", {7'd0, zero_drop}, 8'd0);
            q.delete();
            zd_exp = 1'b0;
        end else begin
            check("zero_drop", {7'd0, zero_drop}, {7'd0, zd_exp});
            check("in_ready", {7'd0, in_ready}, {7'd0, q.size() == 0});
            check("out_valid", {7'd0, out_valid}, {7'd0, q.size() != 0});
            zd_exp = 1'b0;
            if (q.size() != 0) begin
                check("out_code", {5'd0, out_code}, {5'd0, q[0].code});
                check("out_last", {7'd0, out_last}, {7'd0, q[0].last});
                if (out_ready) void'(q.pop_front());
            end else if (en && in_valid) begin
                if (in_vec == 8'h00) zd_exp = 1'b1;
                else model_push(in_vec);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        in_vec   = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        en = 1'b1;
        out_ready = 1'b1;
        send(8'b1010_0100);
        repeat (5) tick();

        out_ready = 1'b0;
        send(8'h80);
        repeat (4) tick();
        out_ready = 1'b1;
        repeat (3) tick();

        send(8'h00);
        repeat (3) tick();

        en = 1'b0;
        in_vec = 8'hFF;
        in_valid = 1'b1;
        repeat (3) tick();
        en = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();

        send(8'hFF);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        send(8'b0001_0011);
        repeat (5) tick();
        send(8'h01);
        repeat (2) tick();

        for (int n = 0; n < 600; n++) begin
            en        = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1);
            in_vec    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 9) < 7);
            rst_n     = ($urandom_range(0, 99) != 0);
            tick();
        end

        rst_n = 1'b1;
        en = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int n = 0; n < 20 && q.size() != 0; n++) tick();
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d codes still expected, required 0", q.size());
        end
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
